// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the N-channel round-robin arbiter: derived widths and
// one-hot to index conversion.
package rr_arbiter_pkg;

  localparam int unsigned MAX_N = 64;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned hold);
    return $clog2(hold + 1);
  endfunction

  // OR of indices of set bits; exact for one-hot0 input, 0 for all-zero.
  function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Request/acknowledge bundle between requesting agents (master) and the
// arbiter (slave).
interface rr_arbiter_n_if
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
);
  localparam int unsigned IDX_W = idx_w(N);

  logic [N-1:0]     ir;
  logic [N-1:0]     ack;
  logic             ack_valid;
  logic [IDX_W-1:0] ack_idx;

  modport master (output ir, input ack, input ack_valid, input ack_idx);
  modport slave  (input ir, output ack, output ack_valid, output ack_idx);
endinterface

// File: rtl/rr_pick_next.sv
// Combinational cyclic search: first set bit of req at or after start,
// via double-width rotate followed by a lowest-bit priority encoder.
module rr_pick_next
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] start,
  output logic                found,
  output logic [idx_w(N)-1:0] idx
);
  localparam int unsigned IDX_W = idx_w(N);
  localparam int unsigned SW    = IDX_W + 1;

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [SW-1:0]    sum;

  assign rot   = N'({req, req} >> start);
  assign found = |req;

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  // Map rotated offset back to an absolute index modulo N.
  always_comb begin
    sum = SW'(start) + SW'(off);
    if (sum >= SW'(N)) sum = sum - SW'(N);
    idx = IDX_W'(sum);
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-channel round-robin arbiter with latched requests, registered one-hot
// acknowledge and a bounded hold length per grant.
module rr_arbiter_n
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned HOLD = 1
) (
  input  logic         clock,
  input  logic         reset,
  rr_arbiter_n_if.slave bus
);
  localparam int unsigned IDX_W = idx_w(N);
  localparam int unsigned CNT_W = cnt_w(HOLD);

  logic [N-1:0]     req_q, req_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic             grantee_req;
  logic             others;
  logic             keep;
  logic [IDX_W-1:0] start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  assign grantee_req = |(req_q & ack_q);
  assign others      = |(req_q & ~ack_q);
  assign keep        = grantee_req && (!others || (hold_q < CNT_W'(HOLD - 1)));
  assign start       = (last_q == IDX_W'(N - 1)) ? '0 : last_q + IDX_W'(1);

  rr_pick_next #(.N(N)) u_pick (
    .req   (req_q),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Decision mux: idle, keep current grantee, or rotate to next requester.
  always_comb begin
    req_d  = bus.ir;
    ack_d  = ack_q;
    last_d = last_q;
    hold_d = hold_q;
    if (req_q == '0) begin
      ack_d  = '0;
      hold_d = '0;
    end else if (keep) begin
      if (hold_q != CNT_W'(HOLD)) hold_d = hold_q + CNT_W'(1);
    end else if (pick_found) begin
      ack_d  = N'(1) << pick_idx;
      last_d = pick_idx;
      hold_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q  <= '0;
      ack_q  <= '0;
      last_q <= IDX_W'(N - 1);
      hold_q <= '0;
    end else begin
      req_q  <= req_d;
      ack_q  <= ack_d;
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.ack_valid = |ack_q;
  assign bus.ack_idx   = IDX_W'(onehot_to_idx(MAX_N'(ack_q)));

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: three configurations checked every cycle against a
// queued reference model, plus directed traces and a fairness bound.
module tb_rr_arbiter_n;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ack;
    int         last;
    int         hold;
  } mst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   started = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mst_t ma, mb, mc;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic [3:0] q_c[$];
  int   wait_b[4];

  rr_arbiter_n_if #(.N(4)) if_a ();
  rr_arbiter_n_if #(.N(4)) if_b ();
  rr_arbiter_n_if #(.N(2)) if_c ();

  rr_arbiter_n #(.N(4), .HOLD(1)) dut_a (.clock(clk), .reset(rst), .bus(if_a));
  rr_arbiter_n #(.N(4), .HOLD(3)) dut_b (.clock(clk), .reset(rst), .bus(if_b));
  rr_arbiter_n #(.N(2), .HOLD(1)) dut_c (.clock(clk), .reset(rst), .bus(if_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model: cyclic search by modular index arithmetic.
  function automatic mst_t mstep(input mst_t s, input logic [3:0] ir, input int n,
                                 input int hmax, input logic r);
    mst_t t;
    int   g;
    int   c;
    bit   done;
    logic oth;
    t = s;
    if (r) begin
      t.req = '0; t.ack = '0; t.last = n - 1; t.hold = 0;
      return t;
    end
    t.req = ir & 4'((1 << n) - 1);
    if (s.req == 4'b0) begin
      t.ack  = '0;
      t.hold = 0;
    end else begin
      g = -1;
      for (int i = 0; i < n; i++) if (s.ack[i]) g = i;
      oth = |(s.req & ~s.ack);
      if (g >= 0 && s.req[g] && (!oth || s.hold < hmax - 1)) begin
        t.hold = (s.hold < hmax) ? s.hold + 1 : hmax;
      end else begin
        done = 1'b0;
        for (int k = 1; k <= n; k++) begin
          c = (s.last + k) % n;
          if (!done && s.req[c]) begin
            t.ack  = 4'b0001 << c;
            t.last = c;
            t.hold = 0;
            done   = 1'b1;
          end
        end
      end
    end
    return t;
  endfunction

  // Expected acks pushed as the model consumes each edge's stimulus.
  always @(posedge clk) begin
    if (started || rst) begin
      q_a.push_back(mstep(ma, if_a.ir, 4, 1, rst).ack);
      q_b.push_back(mstep(mb, if_b.ir, 4, 3, rst).ack);
      q_c.push_back(mstep(mc, {2'b00, if_c.ir}, 2, 1, rst).ack);
    end
    ma <= mstep(ma, if_a.ir, 4, 1, rst);
    mb <= mstep(mb, if_b.ir, 4, 3, rst);
    mc <= mstep(mc, {2'b00, if_c.ir}, 2, 1, rst);
    started <= started | rst;
  end

  always @(negedge clk) begin
    if (started) begin
      if (q_a.size() == 0) chk("sb_a_empty", 32'(0), 32'(1));
      else begin
        chk("sb_a_ack", 32'(if_a.ack), 32'(q_a[0]));
        chk("sb_a_idx", 32'(if_a.ack_idx), 32'(idx_of(q_a[0])));
        chk("sb_a_vld", 32'(if_a.ack_valid), 32'(|q_a[0]));
        void'(q_a.pop_front());
      end
      if (q_b.size() == 0) chk("sb_b_empty", 32'(0), 32'(1));
      else begin
        chk("sb_b_ack", 32'(if_b.ack), 32'(q_b[0]));
        chk("sb_b_idx", 32'(if_b.ack_idx), 32'(idx_of(q_b[0])));
        void'(q_b.pop_front());
      end
      if (q_c.size() == 0) chk("sb_c_empty", 32'(0), 32'(1));
      else begin
        chk("sb_c_ack", 32'(if_c.ack), 32'(q_c[0]));
        chk("sb_c_idx", 32'(if_c.ack_idx), 32'(idx_of(q_c[0])));
        void'(q_c.pop_front());
      end
      chk("onehot_a", 32'($onehot0(if_a.ack)), 32'(1));
      chk("onehot_b", 32'($onehot0(if_b.ack)), 32'(1));
      // A latched request on B must be served within (N-1)*HOLD+1 cycles.
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("fair_b%0d", i),
            32'((((mb.req[i] && !if_b.ack[i]) ? wait_b[i] + 1 : 0) <= 10)), 32'(1));
        wait_b[i] <= (mb.req[i] && !if_b.ack[i]) ? wait_b[i] + 1 : 0;
      end
    end
  end

  initial begin
    logic [3:0] seq_all[5];
    logic [3:0] seq_h3[9];
    logic [1:0] seq_c[4];
    seq_all = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_h3  = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100,
                4'b0001, 4'b0001, 4'b0001};
    seq_c   = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) wait_b[i] = 0;
    if_a.ir = '0;
    if_b.ir = '0;
    if_c.ir = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ack", 32'(if_a.ack), 32'(0));
      chk("idle_vld", 32'(if_a.ack_valid), 32'(0));
      chk("idle_idx", 32'(if_a.ack_idx), 32'(0));
    end

    // Single request: two-cycle latency.
    if_a.ir = 4'b0100;
    tick();
    chk("single_lat1", 32'(if_a.ack), 32'(0));
    tick();
    chk("single_ack", 32'(if_a.ack), 32'(4'b0100));
    chk("single_idx", 32'(if_a.ack_idx), 32'(2));
    tick();
    chk("single_hold", 32'(if_a.ack), 32'(4'b0100));

    // All request, HOLD=1 rotation, then reset mid-operation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_a.ir = 4'b1111;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("all_rot", 32'(if_a.ack), 32'(seq_all[i]));
      tick();
    end
    tick();
    chk("pre_rst", 32'(if_a.ack), 32'(4'b0100));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", 32'(if_a.ack), 32'(0));
    tick();
    chk("post_rst0", 32'(if_a.ack), 32'(0));
    tick();
    chk("post_rst1", 32'(if_a.ack), 32'(4'b0001));

    // Requester drop, then all drop.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_a.ir = 4'b1010;
    tick();
    tick();
    chk("drop_pre", 32'(if_a.ack), 32'(4'b0010));
    if_a.ir = 4'b1000;
    tick();
    tick();
    chk("drop_pass", 32'(if_a.ack), 32'(4'b1000));
    if_a.ir = 4'b0000;
    tick();
    tick();
    chk("drop_all", 32'(if_a.ack), 32'(0));

    // HOLD=3 bursts, then a lone requester keeps the grant.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_b.ir = 4'b0101;
    tick();
    tick();
    for (int i = 0; i < 9; i++) begin
      chk("h3_burst", 32'(if_b.ack), 32'(seq_h3[i]));
      if (i == 8) if_b.ir = 4'b0001;
      tick();
    end
    chk("h3_tail", 32'(if_b.ack), 32'(4'b0100));
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("h3_sole", 32'(if_b.ack), 32'(4'b0001));
      tick();
    end
    if_b.ir = '0;

    // Two-channel legacy alternation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_c.ir = 2'b11;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("n2_alt", 32'(if_c.ack), 32'(seq_c[i]));
      tick();
    end
    if_c.ir = 2'b10;
    tick();
    tick();
    chk("n2_sole", 32'(if_c.ack), 32'(2'b10));

    // Random traffic with occasional resets, checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      if_a.ir = 4'($urandom);
      if_b.ir = 4'($urandom);
      if_c.ir = 2'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    if_a.ir = '0;
    if_b.ir = '0;
    if_c.ir = '0;
    tick();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- Parametrised N-channel round-robin arbiter; successor to the two-channel CHARME99-style arbiter.
- Raw request inputs are latched one cycle, then arbitrated into a registered one-hot acknowledge vector.
- Adds N-way rotating priority, a configurable maximum hold (burst) length per grant, and an encoded grant index.
- Sits between requesting agents and a shared resource; drop-in for the 2-channel arbiter when N=2, HOLD=1.

Parameters:
- N, 4, number of requesting channels (>=2).
- HOLD, 1, maximum consecutive cycles one channel keeps ack while any other latched request is pending (>=1); HOLD=1 gives strict alternation.
- IDX_W, $clog2(N), width of ack_idx (derived, not overridden).

Ports:
- clock  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ir  input  N  raw request per channel, sampled every posedge.
- ack  output  N  registered acknowledge; one-hot or all-zero.
- ack_valid  output  1  OR-reduction of ack (combinational from ack register).
- ack_idx  output  IDX_W  index of the set ack bit; 0 when ack_valid=0.

Behaviour:
- State registers: req[N] (latched ir), ack[N], last[IDX_W] (most recent grantee), hold_cnt[$clog2(HOLD+1)].
- Reset values (sync, applied at the posedge where reset=1): req=0, ack=0, hold_cnt=0, last=N-1, so channel 0 wins the first contention.
- Every non-reset posedge: req <= ir, and ack/last/hold_cnt update from the PRE-edge req and ack.
- Latency: ir at edge k appears in req after edge k; it influences ack after edge k+1. Minimum ir-to-ack latency is 2 cycles.
- Let g be the current grantee (the set bit of ack) and others = |(req & ~ack).
- Decision, in priority order:
  1. req==0: ack<=0; hold_cnt<=0; last unchanged.
  2. ack!=0, req[g]=1, and (others==0 or hold_cnt<HOLD-1): keep g; hold_cnt<=hold_cnt+1, saturating at HOLD.
  3. Otherwise: new grantee = first set bit of req, searching cyclically from last+1 through last (wrapping at N-1 -> 0). Then ack<=onehot(new); last<=new; hold_cnt<=0.
- Consequence of step 3: the previous grantee is re-selected only if it is the sole requester.
- No idle gap when the grant moves between requesters. ack drops to 0 only when req==0.
- Dropped request: if req[g] falls, g loses ack at the next edge, and the grant passes to the next requester by rotation, if any.
- Simultaneous new requests with ack==0: winner is the nearest index after last (cyclic).
- Reset mid-burst: reset overrides everything. ack is 0 on the following cycle, and arbitration restarts from channel 0.
- Required invariants (carried as bench assertions):
  - ack is one-hot0 at all times.
  - req==0 |-> ##1 ack==0.
  - Single req[i] |-> ##1 ack[i].
  - With HOLD=1: req[i] && ack[j] (j!=i) |-> ##1 ack!=onehot(j) unless req[j] is the only request.
  - Fairness: a continuously latched req[i] receives ack within (N-1)*HOLD+1 cycles.

Decomposition:
- Package rr_arbiter_pkg: function onehot_to_idx, and localparam helpers for IDX_W and hold counter width.
- Sub-module rr_pick_next: purely combinational. Inputs req[N] and start index; outputs found and idx of the first set bit at or after start, cyclic. Implement as a double-width rotate plus priority encode.
- Top: registers, hold logic and decision mux.

Test Plan:
- Reset then idle (N=4, HOLD=1): ir=0000 for 5 cycles -> ack=0000, ack_valid=0, ack_idx=0 throughout.
- Single request: ir=0100 from cycle 1 -> ack=0100 from cycle 3 onward; ack_idx=2.
- All request, HOLD=1: ir=1111 held -> ack sequence 0001, 0010, 0100, 1000, 0001 ... (one cycle each, no zero gap).
- HOLD=3, ir=0101 held -> ack 0001 for 3 cycles, 0100 for 3 cycles, repeat. Then ir=0001 -> ack stays 0001 indefinitely, hold_cnt saturating.
- Requester drop: ack=0010 with ir=1010, then ir changes to 1000 -> two cycles later ack=1000. Then ir=0000 -> two cycles later ack=0000.
- Reset mid-operation: ir=1111, ack=0100, assert reset one cycle -> next cycle ack=0000. After release, first grant is 0001. N=2/HOLD=1 regression reproduces the legacy 2-channel ack traces exactly.
